// File: rtl/debug_host_pkg.sv
// Shared constants and FSM encoding for the debug host agent.
package debug_host_pkg;

    localparam logic [31:0] HALT_WORD = 32'h7FFF_FFFE;

    localparam int unsigned PC_WORDS    = 1;
    localparam int unsigned REG_WORDS   = 32;
    localparam int unsigned MEM_WORDS   = 20;
    localparam int unsigned LATCH_WORDS = 20;
    localparam int unsigned DUMP_TOTAL  = PC_WORDS + REG_WORDS + MEM_WORDS + LATCH_WORDS;

    typedef enum logic [3:0] {
        IDLE,
        SEND_MODE,
        WAIT_MODE,
        FETCH,
        SEND_INSTR,
        WAIT_INSTR,
        SEND_HALT,
        WAIT_HALT,
        RECV_DUMP,
        DUMP_DONE,
        SEND_STEP,
        WAIT_STEP
    } state_t;

endpackage

// File: rtl/dump_capture_ram.sv
// 128x32 capture buffer: one write port, one registered read port.
module dump_capture_ram (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [6:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [6:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [128];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/debug_host_agent.sv
// Host-side debug agent: streams a program to the target over UART, then captures dumps.
// Optional dump watchdog enabled by defining DEBUG_HOST_TIMEOUT_EN.
module debug_host_agent
    import debug_host_pkg::*;
#(
    parameter int unsigned DUMP_WORDS     = DUMP_TOTAL,
    parameter logic [31:0] STEP_TOKEN     = 32'h0000_0001,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic [7:0]  prog_len,
    output logic [7:0]  prog_addr,
    input  logic [31:0] prog_data,
    output logic        tx_start,
    output logic [31:0] tx_data,
    input  logic        tx_dataready,
    input  logic        rx_write,
    input  logic [31:0] rx_dout,
    input  logic [6:0]  dump_raddr,
    output logic [31:0] dump_rdata,
    output logic        busy,
    output logic        dump_valid,
    output logic [6:0]  dump_count,
    output logic        error
);

    localparam logic [6:0] LAST_SLOT = 7'(DUMP_WORDS - 1);

    state_t      state, state_nxt;
    logic        mode_q;
    logic [7:0]  len_q;
    logic [31:0] tx_word, tx_hold;
    logic        last_instr, rx_accept, session_start, timeout, range_q;
    logic [31:0] ram_rdata;

    assign last_instr    = ({1'b0, prog_addr} + 9'd1) == {1'b0, len_q};
    assign rx_accept     = (state == RECV_DUMP) && rx_write;
    assign session_start = (state_nxt == SEND_MODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = SEND_MODE;
            SEND_MODE:  state_nxt = WAIT_MODE;
            WAIT_MODE:  if (tx_dataready) state_nxt = (len_q == 8'd0) ? SEND_HALT : FETCH;
            FETCH:      state_nxt = SEND_INSTR;
            // An embedded halt word is forwarded as the halt itself
            SEND_INSTR: state_nxt = (prog_data == HALT_WORD) ? WAIT_HALT : WAIT_INSTR;
            WAIT_INSTR: if (tx_dataready) state_nxt = last_instr ? SEND_HALT : FETCH;
            SEND_HALT:  state_nxt = WAIT_HALT;
            WAIT_HALT:  if (tx_dataready) state_nxt = mode_q ? SEND_STEP : RECV_DUMP;
            RECV_DUMP: begin
                if (rx_write && dump_count == LAST_SLOT) state_nxt = DUMP_DONE;
                else if (timeout)                        state_nxt = IDLE;
            end
            DUMP_DONE: begin
                if (mode_q && step) state_nxt = SEND_STEP;
                else if (start)     state_nxt = SEND_MODE;
            end
            SEND_STEP:  state_nxt = WAIT_STEP;
            WAIT_STEP:  if (tx_dataready) state_nxt = RECV_DUMP;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_start   = 1'b0;
        tx_word    = '0;
        busy       = 1'b1;
        dump_valid = 1'b0;
        case (state)
            SEND_MODE:  begin tx_start = 1'b1; tx_word = {31'b0, mode_q}; end
            SEND_INSTR: begin tx_start = 1'b1; tx_word = prog_data;       end
            SEND_HALT:  begin tx_start = 1'b1; tx_word = HALT_WORD;       end
            SEND_STEP:  begin tx_start = 1'b1; tx_word = STEP_TOKEN;      end
            IDLE:       busy = 1'b0;
            DUMP_DONE:  begin busy = 1'b0; dump_valid = 1'b1;             end
            default:    ;
        endcase
        // The word is captured on its send cycle and held through the wait
        tx_data = tx_start ? tx_word : tx_hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 1'b0;
            len_q      <= '0;
            prog_addr  <= '0;
            tx_hold    <= '0;
            dump_count <= '0;
            range_q    <= 1'b0;
        end else begin
            range_q <= 32'(dump_raddr) < DUMP_WORDS;
            if (tx_start) tx_hold <= tx_word;
            if (session_start) begin
                mode_q     <= step_mode;
                len_q      <= prog_len;
                prog_addr  <= '0;
                dump_count <= '0;
            end else if (state == DUMP_DONE && state_nxt == SEND_STEP) begin
                dump_count <= '0;
            end else if (rx_accept) begin
                dump_count <= dump_count + 7'd1;
            end
            if (state == WAIT_INSTR && tx_dataready && !last_instr) begin
                prog_addr <= prog_addr + 8'd1;
            end
        end
    end

`ifdef DEBUG_HOST_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;

    assign timeout = (state == RECV_DUMP) && !rx_write && (timer == TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
            error <= 1'b0;
        end else begin
            if (state != RECV_DUMP || rx_write) timer <= '0;
            else if (!timeout)                  timer <= timer + 1'b1;
            if (session_start) error <= 1'b0;
            else if (timeout)  error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    dump_capture_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (rx_accept),
        .waddr (dump_count),
        .wdata (rx_dout),
        .raddr (dump_raddr),
        .rdata (ram_rdata)
    );

    assign dump_rdata = range_q ? ram_rdata : '0;

endmodule

// File: tb/tb_debug_host_agent.sv
// Self-checking bench for debug_host_agent: tx scoreboard queue, UART responder, dump buffer model.
module tb_debug_host_agent;
    import debug_host_pkg::*;

`ifdef DEBUG_HOST_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 100;
`else
    localparam int unsigned TO_CYCLES = 2_000_000;
`endif
    localparam logic [31:0] STEP_TOK = 32'h0000_0001;
    localparam int unsigned NWORDS   = 73;

    logic        clk, rst, start, step_mode, step;
    logic [7:0]  prog_len, prog_addr;
    logic [31:0] prog_data, tx_data, rx_dout, dump_rdata;
    logic        tx_start, tx_dataready, rx_write, busy, dump_valid, error;
    logic [6:0]  dump_raddr, dump_count;

    debug_host_agent #(
        .DUMP_WORDS     (NWORDS),
        .STEP_TOKEN     (STEP_TOK),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .step_mode    (step_mode),
        .step         (step),
        .prog_len     (prog_len),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_dataready (tx_dataready),
        .rx_write     (rx_write),
        .rx_dout      (rx_dout),
        .dump_raddr   (dump_raddr),
        .dump_rdata   (dump_rdata),
        .busy         (busy),
        .dump_valid   (dump_valid),
        .dump_count   (dump_count),
        .error        (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] rom [256];
    always @(posedge clk) prog_data <= rom[prog_addr];

    int unsigned n_cmp = 0, n_err = 0;
    logic [31:0] tx_q [$];
    int unsigned n_tx = 0, n_push = 0;
    logic [31:0] exp_buf [NWORDS];
    int unsigned rx_idx = 0;
    logic        tx_pending = 1'b0;
    int unsigned uart_delay = 0;
    int unsigned pa_max = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [31:0] w);
        tx_q.push_back(w);
        n_push++;
    endtask

    // UART model: score each sent word, then acknowledge after a short delay
    initial begin
        int unsigned d;
        logic [31:0] last;
        tx_dataready = 1'b0;
        @(negedge clk);
        forever begin
            if (tx_start === 1'b1) begin
                tx_pending = 1'b1;
                n_tx++;
                if (tx_q.size() == 0) check("tx_extra", 32'(n_tx), 32'(n_push));
                else                  check("tx_word", tx_data, tx_q.pop_front());
                last = tx_data;
                d = (uart_delay != 0) ? uart_delay : $urandom_range(1, 3);
                repeat (d) begin
                    @(negedge clk);
                    check("tx_single", 32'(tx_start), 32'd0);
                end
                check("tx_hold", tx_data, last);
                tx_dataready = 1'b1;
                @(negedge clk);
                tx_dataready = 1'b0;
                tx_pending   = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (32'(prog_addr) > pa_max) pa_max = 32'(prog_addr);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input logic mode, input logic [7:0] len);
        step_mode = mode;
        prog_len  = len;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        step_mode = ~mode;
        prog_len  = 8'hFF;
        rx_idx    = 0;
        pa_max    = 0;
    endtask

    task automatic wait_tx_done(input string tag);
        int unsigned k = 0;
        while ((tx_q.size() != 0 || tx_pending) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(tx_q.size()) + 32'(tx_pending), 32'd0);
    endtask

    task automatic send_rx(input int unsigned n);
        logic [31:0] w;
        for (int unsigned i = 0; i < n; i++) begin
            w = $urandom();
            rx_write = 1'b1;
            rx_dout  = w;
            if (rx_idx < NWORDS) exp_buf[rx_idx] = w;
            rx_idx++;
            @(negedge clk);
        end
        rx_write = 1'b0;
    endtask

    task automatic read_buf(input logic [6:0] a, input logic [31:0] exp, input string tag);
        dump_raddr = a;
        @(negedge clk);
        check(tag, dump_rdata, exp);
    endtask

    initial begin
        int unsigned base;
        int unsigned k;
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; prog_len = '0;
        rx_write = 1'b0; rx_dout = '0; dump_raddr = '0;
        for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(dump_valid), 0);
        check("rst_count", 32'(dump_count), 0);
        check("rst_error", 32'(error), 0);
        check("rst_txs", 32'(tx_start), 0);
        check("rst_txd", tx_data, 0);
        check("rst_paddr", 32'(prog_addr), 0);
        check("rst_rdata", dump_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Three-instruction run-to-end session
        rom[0] = 32'hAAAA_0001; rom[1] = 32'hBBBB_0002; rom[2] = 32'hCCCC_0003;
        push_tx(32'h0); push_tx(32'hAAAA_0001); push_tx(32'hBBBB_0002);
        push_tx(32'hCCCC_0003); push_tx(HALT_WORD);
        do_start(1'b0, 8'd3);
        check("A_busy", 32'(busy), 1);
        wait_tx_done("A_tx_done");
        check("A_count0", 32'(dump_count), 0);
        send_rx(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_rx(52);
        check("A_count72", 32'(dump_count), 72);
        check("A_valid_early", 32'(dump_valid), 0);
        send_rx(1);
        check("A_valid", 32'(dump_valid), 1);
        check("A_count73", 32'(dump_count), 73);
        check("A_busy_done", 32'(busy), 0);
        check("A_addr_max", pa_max, 2);
        rx_write = 1'b1; rx_dout = 32'h5555_AAAA;
        @(negedge clk);
        rx_write = 1'b0;
        check("A_rx_discard", 32'(dump_count), 73);
        read_buf(7'd5, exp_buf[5], "A_buf5");
        read_buf(7'd0, exp_buf[0], "A_buf0");
        read_buf(7'd72, exp_buf[72], "A_buf72");
        read_buf(7'd73, 32'h0, "A_buf73");
        read_buf(7'd127, 32'h0, "A_buf127");
        check("A_error", 32'(error), 0);

        // Empty program, started from DUMP_DONE
        push_tx(32'h0); push_tx(HALT_WORD);
        do_start(1'b0, 8'd0);
        check("B_valid_clr", 32'(dump_valid), 0);
        check("B_count_clr", 32'(dump_count), 0);
        wait_tx_done("B_tx_done");
        check("B_addr_max", pa_max, 0);
        send_rx(NWORDS);
        check("B_valid", 32'(dump_valid), 1);
        read_buf(7'd0, exp_buf[0], "B_buf0");

        // Embedded halt word cuts the program short
        rom[0] = 32'h1234_5678; rom[1] = HALT_WORD; rom[2] = 32'h2222_2222; rom[3] = 32'h3333_3333;
        push_tx(32'h0); push_tx(32'h1234_5678); push_tx(HALT_WORD);
        do_start(1'b0, 8'd4);
        wait_tx_done("C_tx_done");
        check("C_addr_max", pa_max, 1);
        send_rx(NWORDS);
        check("C_valid", 32'(dump_valid), 1);
        read_buf(7'd40, exp_buf[40], "C_buf40");

        // Step mode, with a stray rx word while an instruction is in flight
        rom[0] = 32'h0F0F_0001; rom[1] = 32'h0F0F_0002;
        base = n_push;
        push_tx(32'h1); push_tx(32'h0F0F_0001); push_tx(32'h0F0F_0002);
        push_tx(HALT_WORD); push_tx(STEP_TOK);
        uart_delay = 3;
        do_start(1'b1, 8'd2);
        k = 0;
        while (n_tx < base + 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("D_first_instr", 32'(n_tx >= base + 2), 1);
        @(negedge clk);
        rx_write = 1'b1; rx_dout = 32'hBAD0_0001;
        @(negedge clk);
        rx_write = 1'b0;
        check("D_inject", 32'(dump_count), 0);
        uart_delay = 0;
        wait_tx_done("D_tx_done");
        send_rx(NWORDS);
        check("D_valid", 32'(dump_valid), 1);
        check("D_count", 32'(dump_count), 73);
        read_buf(7'd0, exp_buf[0], "D_buf0");
        push_tx(STEP_TOK);
        rx_idx = 0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("D_step_valid", 32'(dump_valid), 0);
        check("D_step_count", 32'(dump_count), 0);
        check("D_step_busy", 32'(busy), 1);
        wait_tx_done("D_step_tx");
        send_rx(NWORDS);
        check("D_valid2", 32'(dump_valid), 1);
        read_buf(7'd5, exp_buf[5], "D_buf5");
        read_buf(7'd72, exp_buf[72], "D_buf72");

        // Reset in the middle of a dump
        rom[0] = 32'h7777_0000; rom[1] = 32'h7777_0001;
        push_tx(32'h0); push_tx(32'h7777_0000); push_tx(32'h7777_0001); push_tx(HALT_WORD);
        do_start(1'b0, 8'd2);
        wait_tx_done("E_tx_done");
        send_rx(10);
        check("E_count10", 32'(dump_count), 10);
        dump_raddr = 7'd3;
        rst = 1'b1;
        @(negedge clk);
        check("E_busy", 32'(busy), 0);
        check("E_count", 32'(dump_count), 0);
        check("E_valid", 32'(dump_valid), 0);
        check("E_txs", 32'(tx_start), 0);
        check("E_txd", tx_data, 0);
        check("E_paddr", 32'(prog_addr), 0);
        check("E_error", 32'(error), 0);
        check("E_rdata", dump_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef DEBUG_HOST_TIMEOUT_EN
        // Dump stalls after ten words
        push_tx(32'h0); push_tx(HALT_WORD);
        do_start(1'b0, 8'd0);
        wait_tx_done("F_tx_done");
        send_rx(10);
        repeat (TO_CYCLES - 1) @(negedge clk);
        check("F_busy_pre", 32'(busy), 1);
        check("F_error_pre", 32'(error), 0);
        @(negedge clk);
        check("F_error", 32'(error), 1);
        check("F_idle", 32'(busy), 0);
        check("F_valid", 32'(dump_valid), 0);
        push_tx(32'h0); push_tx(HALT_WORD);
        do_start(1'b0, 8'd0);
        check("F_error_clr", 32'(error), 0);
        wait_tx_done("F_tx_done2");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debug_host_agent.md
DEBUG_HOST_AGENT -- requirements
Module: debug_host_agent

Interface
REQ-001 Parameter DUMP_WORDS, default 73, number of words in one target dump (1 PC + 32 registers + 20 memory + 20 latch).
REQ-002 Parameter STEP_TOKEN, default 32'h00000001, word sent to request one debug step.
REQ-003 Parameter TIMEOUT_CYCLES, default 2_000_000, dump inter-word watchdog limit.
REQ-004 clk input 1: clock; rst input 1: reset, asynchronous, active-high.
REQ-005 start input 1: one-cycle pulse that begins a session; step_mode input 1: sampled at start, 1 = step debug, 0 = run-to-end.
REQ-006 step input 1: one-cycle pulse requesting the next step dump.
REQ-007 prog_len input 8: instruction count, sampled at start; prog_addr output 8: program ROM address; prog_data input 32: ROM word, valid one cycle after prog_addr.
REQ-008 tx_start output 1: one-cycle word-send strobe; tx_data output 32: word to send; tx_dataready input 1: UART word-sent indication.
REQ-009 rx_write input 1: received-word strobe; rx_dout input 32: received word.
REQ-010 dump_raddr input 7, dump_rdata output 32: capture buffer read port.
REQ-011 busy output 1; dump_valid output 1; dump_count output 7; error output 1.

Function
REQ-012 States: IDLE, SEND_MODE, WAIT_MODE, FETCH, SEND_INSTR, WAIT_INSTR, SEND_HALT, WAIT_HALT, RECV_DUMP, DUMP_DONE, SEND_STEP, WAIT_STEP.
REQ-013 IDLE + start: latch step_mode and prog_len, clear dump_count, dump_valid and error, then go to SEND_MODE. start is ignored in every other state.
REQ-014 Each SEND_* state drives tx_data and pulses tx_start for exactly one cycle, then enters its WAIT_* state. tx_data stays stable until the WAIT_* state exits.
REQ-015 A WAIT_* state exits on the first cycle with tx_dataready=1. No second tx_start is issued before that cycle.
REQ-016 SEND_MODE sends {31'b0, step_mode}. WAIT_MODE goes to FETCH, or to SEND_HALT if prog_len=0.
REQ-017 FETCH drives prog_addr for one cycle. SEND_INSTR sends prog_data. prog_addr runs 0..prog_len-1.
REQ-018 If prog_data equals 32'h7FFFFFFE, send it as the halt word and go to WAIT_HALT, skipping the remaining instructions.
REQ-019 After the last instruction, SEND_HALT sends 32'h7FFFFFFE. WAIT_HALT then goes to RECV_DUMP, or to SEND_STEP if step_mode=1.
REQ-020 RECV_DUMP: each rx_write writes rx_dout to buffer[dump_count] and increments dump_count. When dump_count reaches DUMP_WORDS, go to DUMP_DONE.
REQ-021 rx_write outside RECV_DUMP is discarded and changes no state.
REQ-022 DUMP_DONE: dump_valid=1. If step_mode=1 and step pulses: clear dump_valid and dump_count, then go to SEND_STEP. Otherwise hold until start, which behaves as in IDLE.
REQ-023 SEND_STEP sends STEP_TOKEN. WAIT_STEP goes to RECV_DUMP.
REQ-024 busy=1 in every state except IDLE and DUMP_DONE.
REQ-025 dump_rdata is registered with 1-cycle latency. Addresses at or above DUMP_WORDS return 0.
REQ-026 Simultaneous rx_write and the final-word transition: the word is stored before dump_valid rises on the next cycle.

Reset
REQ-027 rst forces state IDLE, tx_start=0, tx_data=0, prog_addr=0, dump_count=0, dump_valid=0, error=0, busy=0, dump_rdata=0.
REQ-028 rst mid-session abandons the session and leaves buffer contents undefined.

Configuration
REQ-029 Macro DEBUG_HOST_TIMEOUT_EN defined: in RECV_DUMP, a counter cleared on every rx_write runs up to TIMEOUT_CYCLES. On reaching the limit, set error=1 and go to IDLE. error holds until the next start.
REQ-030 Macro DEBUG_HOST_TIMEOUT_EN undefined: no counter exists, RECV_DUMP waits indefinitely, and error is tied to 0.

Structure
REQ-031 Package debug_host_pkg holds HALT_WORD=32'h7FFFFFFE, the dump section sizes (1, 32, 20, 20), and the state encoding.
REQ-032 Sub-module dump_capture_ram: 128x32, one write port, one registered read port.

Verification
REQ-033 prog_len=3, ROM {A,B,C}, step_mode=0 -> tx words 0x0, A, B, C, 0x7FFFFFFE, each after tx_dataready; then 73 rx words -> dump_valid=1, dump_count=73, buffer[5] equals the 6th rx word.
REQ-034 prog_len=0 -> tx words 0x0 then 0x7FFFFFFE only; prog_addr never leaves 0.
REQ-035 ROM word 1 = 0x7FFFFFFE, prog_len=4 -> tx words 0x0, w0, 0x7FFFFFFE; no further instruction sent.
REQ-036 step_mode=1 -> tx 0x1, program, halt, 0x00000001; after 73 rx words, dump_valid=1; step pulse -> dump_valid=0 and a second 0x00000001 sent.
REQ-037 rx_write during WAIT_INSTR -> dump_count remains 0; rst asserted in RECV_DUMP -> all outputs at reset values next cycle.
REQ-038 DEBUG_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100, 10 rx words then silence -> error=1 and state IDLE 100 cycles after the last word.
